// File: rtl/alarm_set_ctrl.sv
// Alarm-time entry controller: owns the committed HH:MM alarm digits,
// sequences digit editing from three key pulses, detects the rising edge
// of an alarm match against the running time and drives the ring output.
module alarm_set_ctrl #(
    parameter int RING_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       key_ok,
    input  logic       sec_tick,
    input  logic [3:0] now_h1,
    input  logic [3:0] now_h2,
    input  logic [3:0] now_m1,
    input  logic [3:0] now_m2,
    output logic [3:0] alarm_h1,
    output logic [3:0] alarm_h2,
    output logic [3:0] alarm_m1,
    output logic [3:0] alarm_m2,
    output logic [3:0] disp_h1,
    output logic [3:0] disp_h2,
    output logic [3:0] disp_m1,
    output logic [3:0] disp_m2,
    output logic       editing,
    output logic [1:0] digit_sel,
    output logic       blink,
    output logic       armed,
    output logic       ring
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_H1 = 3'd1,
        S_EDIT_H2 = 3'd2,
        S_EDIT_M1 = 3'd3,
        S_EDIT_M2 = 3'd4,
        S_RING    = 3'd5
    } state_t;

    // Digit vectors: index 0=H1, 1=H2, 2=M1, 3=M2 (same encoding as digit_sel)
    state_t           state_q,     state_d;
    logic [3:0][3:0]  alarm_q,     alarm_d;
    logic [3:0][3:0]  edit_q,      edit_d;
    logic [3:0][3:0]  disp_q,      disp_d;
    logic             armed_q,     armed_d;
    logic             ring_q,      ring_d;
    logic             blink_q,     blink_d;
    logic             editing_q,   editing_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [7:0]       cnt_q,       cnt_d;
    logic             match_q;
    logic             match;
    logic             trigger;
    logic             any_key;

    // Increment one edit digit with BCD wrap; hours are limited to 23
    function automatic logic [3:0][3:0] bump(input logic [3:0][3:0] d,
                                             input logic [1:0]      sel);
        logic [3:0][3:0] r;
        r = d;
        case (sel)
            2'd0: begin
                r[0] = (d[0] >= 4'd2) ? 4'd0 : d[0] + 4'd1;
                // H1 stepping to 2 must not leave an illegal 24..29 hour
                if (r[0] == 4'd2 && d[1] > 4'd3) r[1] = 4'd0;
            end
            2'd1: r[1] = (d[1] >= ((d[0] == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : d[1] + 4'd1;
            2'd2: r[2] = (d[2] >= 4'd5) ? 4'd0 : d[2] + 4'd1;
            default: r[3] = (d[3] >= 4'd9) ? 4'd0 : d[3] + 4'd1;
        endcase
        return r;
    endfunction

    // Digit selected by an edit state; 0 outside edit
    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            S_EDIT_H2: return 2'd1;
            S_EDIT_M1: return 2'd2;
            S_EDIT_M2: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    assign match   = (now_h1 == alarm_q[0]) && (now_h2 == alarm_q[1]) &&
                     (now_m1 == alarm_q[2]) && (now_m2 == alarm_q[3]);
    assign trigger = match && !match_q && armed_q && (state_q == S_IDLE);
    assign any_key = key_set || key_inc || key_ok;

    // Next-state logic: key handling (ok > set > inc), ring timing, blink phase
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        edit_d  = edit_q;
        armed_d = armed_q;
        ring_d  = ring_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_RING;
                    ring_d  = 1'b1;
                    cnt_d   = 8'(RING_SECS);
                end else if (key_ok) begin
                    armed_d = !armed_q;
                end else if (key_set) begin
                    edit_d  = alarm_q;
                    state_d = S_EDIT_H1;
                    blink_d = 1'b1;
                end
            end
            S_EDIT_H1, S_EDIT_H2, S_EDIT_M1, S_EDIT_M2: begin
                if (key_ok) begin
                    alarm_d = edit_q;
                    armed_d = 1'b1;
                    state_d = S_IDLE;
                end else if (key_set) begin
                    case (state_q)
                        S_EDIT_H1: state_d = S_EDIT_H2;
                        S_EDIT_H2: state_d = S_EDIT_M1;
                        S_EDIT_M1: state_d = S_EDIT_M2;
                        default:   state_d = S_EDIT_H1;
                    endcase
                    blink_d = 1'b1;
                end else if (key_inc) begin
                    edit_d  = bump(edit_q, sel_of(state_q));
                    blink_d = 1'b1;
                end else if (sec_tick) begin
                    blink_d = !blink_q;
                end
            end
            S_RING: begin
                // A key only silences; it never edits or toggles armed here
                if (any_key) begin
                    ring_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (sec_tick) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        ring_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ring_d  = 1'b0;
            end
        endcase

        editing_d   = (state_d == S_EDIT_H1) || (state_d == S_EDIT_H2) ||
                      (state_d == S_EDIT_M1) || (state_d == S_EDIT_M2);
        digit_sel_d = sel_of(state_d);
        disp_d      = editing_d ? edit_d : alarm_d;
        if (!editing_d) blink_d = 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            alarm_q     <= '0;
            edit_q      <= '0;
            disp_q      <= '0;
            armed_q     <= 1'b0;
            ring_q      <= 1'b0;
            blink_q     <= 1'b1;
            editing_q   <= 1'b0;
            digit_sel_q <= 2'd0;
            cnt_q       <= 8'd0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            edit_q      <= edit_d;
            disp_q      <= disp_d;
            armed_q     <= armed_d;
            ring_q      <= ring_d;
            blink_q     <= blink_d;
            editing_q   <= editing_d;
            digit_sel_q <= digit_sel_d;
            cnt_q       <= cnt_d;
            match_q     <= match;
        end
    end

    assign alarm_h1  = alarm_q[0];
    assign alarm_h2  = alarm_q[1];
    assign alarm_m1  = alarm_q[2];
    assign alarm_m2  = alarm_q[3];
    assign disp_h1   = disp_q[0];
    assign disp_h2   = disp_q[1];
    assign disp_m1   = disp_q[2];
    assign disp_m2   = disp_q[3];
    assign editing   = editing_q;
    assign digit_sel = digit_sel_q;
    assign blink     = blink_q;
    assign armed     = armed_q;
    assign ring      = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: editing, wrap rules, commit, arming,
// ring trigger/timeout/silence, key priority and asynchronous reset.
module tb_alarm_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_set, key_inc, key_ok, sec_tick;
    logic [3:0] now_h1, now_h2, now_m1, now_m2;
    logic [3:0] alarm_h1, alarm_h2, alarm_m1, alarm_m2;
    logic [3:0] disp_h1, disp_h2, disp_m1, disp_m2;
    logic       editing, blink, armed, ring;
    logic [1:0] digit_sel;

    logic [15:0] alarm_w, disp_w;
    assign alarm_w = {alarm_h1, alarm_h2, alarm_m1, alarm_m2};
    assign disp_w  = {disp_h1, disp_h2, disp_m1, disp_m2};

    int n_cmp = 0;
    int n_err = 0;

    alarm_set_ctrl #(.RING_SECS(30)) dut (
        .clk(clk), .rst(rst),
        .key_set(key_set), .key_inc(key_inc), .key_ok(key_ok), .sec_tick(sec_tick),
        .now_h1(now_h1), .now_h2(now_h2), .now_m1(now_m1), .now_m2(now_m2),
        .alarm_h1(alarm_h1), .alarm_h2(alarm_h2), .alarm_m1(alarm_m1), .alarm_m2(alarm_m2),
        .disp_h1(disp_h1), .disp_h2(disp_h2), .disp_m1(disp_m1), .disp_m2(disp_m2),
        .editing(editing), .digit_sel(digit_sel), .blink(blink), .armed(armed), .ring(ring)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a key combination for one cycle; returns at the negedge after it was sampled
    task automatic keys(input logic s, input logic i, input logic o);
        @(negedge clk);
        key_set = s; key_inc = i; key_ok = o;
        @(negedge clk);
        key_set = 1'b0; key_inc = 1'b0; key_ok = 1'b0;
    endtask

    task automatic incn(input int n);
        for (int k = 0; k < n; k++) keys(1'b0, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic set_now(input logic [15:0] v);
        {now_h1, now_h2, now_m1, now_m2} = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        key_set = 1'b0; key_inc = 1'b0; key_ok = 1'b0; sec_tick = 1'b0;
        set_now(16'h9999);
        idle(2);
        chk("rst_alarm",   alarm_w,   16'h0000);
        chk("rst_disp",    disp_w,    16'h0000);
        chk("rst_armed",   armed,     0);
        chk("rst_ring",    ring,      0);
        chk("rst_blink",   blink,     1);
        chk("rst_sel",     digit_sel, 0);
        chk("rst_editing", editing,   0);
        rst = 1'b0;

        // Enter 21:37 with the H2 wrap at 3 when H1=2
        keys(1, 0, 0);
        chk("t1_editing", editing, 1);
        chk("t1_sel0",    digit_sel, 0);
        incn(2);
        chk("t1_h1", disp_w, 16'h2000);
        keys(1, 0, 0);
        chk("t1_sel1", digit_sel, 1);
        incn(5);
        chk("t1_h2_wrap", disp_w, 16'h2100);
        keys(1, 0, 0);
        incn(3);
        keys(1, 0, 0);
        incn(7);
        chk("t1_disp_pre",  disp_w,  16'h2137);
        chk("t1_alarm_pre", alarm_w, 16'h0000);
        keys(0, 0, 1);
        chk("t1_alarm",   alarm_w, 16'h2137);
        chk("t1_armed",   armed,   1);
        chk("t1_editing0", editing, 0);
        chk("t1_disp",    disp_w,  16'h2137);
        chk("t1_sel_out", digit_sel, 0);

        // Build 19:00, then H1 1->2 forces H2 to 0; blink behaviour; M1 wrap
        keys(1, 0, 0);
        incn(2);
        keys(1, 0, 0);
        incn(8);
        keys(1, 0, 0);
        incn(3);
        keys(1, 0, 0);
        incn(3);
        keys(0, 0, 1);
        chk("t2_alarm1900", alarm_w, 16'h1900);
        keys(1, 0, 0);
        chk("t2_blink_enter", blink, 1);
        incn(1);
        chk("t2_h2_forced", disp_w, 16'h2000);
        tick();
        chk("t2_blink_t1", blink, 0);
        tick();
        chk("t2_blink_t2", blink, 1);
        tick();
        chk("t2_blink_t3", blink, 0);
        keys(1, 0, 0);
        chk("t2_blink_key", blink, 1);
        chk("t2_sel1", digit_sel, 1);
        keys(1, 0, 0);
        chk("t2_sel2", digit_sel, 2);
        incn(5);
        chk("t2_m1_5", disp_w, 16'h2050);
        incn(1);
        chk("t2_m1_wrap", disp_w, 16'h2000);
        chk("t2_alarm_hold", alarm_w, 16'h1900);
        keys(0, 0, 1);
        chk("t2_alarm2000", alarm_w, 16'h2000);
        chk("t2_blink_idle", blink, 1);

        // Alarm 07:15, trigger on now edge, 30-tick auto silence, no retrigger
        set_now(16'h0714);
        keys(1, 0, 0);
        incn(1);
        keys(1, 0, 0);
        incn(7);
        keys(1, 0, 0);
        incn(1);
        keys(1, 0, 0);
        incn(5);
        keys(0, 0, 1);
        chk("t3_alarm", alarm_w, 16'h0715);
        chk("t3_armed", armed, 1);
        idle(2);
        chk("t3_ring_pre", ring, 0);
        set_now(16'h0715);
        @(negedge clk);
        chk("t3_ring_on", ring, 1);
        for (int k = 0; k < 29; k++) tick();
        chk("t3_ring_29", ring, 1);
        tick();
        chk("t3_ring_30", ring, 0);
        chk("t3_editing", editing, 0);
        chk("t3_armed_after", armed, 1);
        idle(5);
        chk("t3_no_retrig", ring, 0);

        // Silence by key_set; key priority in IDLE
        set_now(16'h0714);
        @(negedge clk);
        set_now(16'h0715);
        @(negedge clk);
        chk("t4_ring_on", ring, 1);
        keys(1, 0, 0);
        chk("t4_silenced", ring, 0);
        chk("t4_no_edit", editing, 0);
        chk("t4_armed", armed, 1);
        keys(0, 1, 1);
        chk("t4_ok_inc_armed", armed, 0);
        chk("t4_ok_inc_disp", disp_w, 16'h0715);
        keys(1, 0, 1);
        chk("t4_ok_set_armed", armed, 1);
        chk("t4_ok_set_noedit", editing, 0);
        idle(3);
        chk("t4_no_retrig", ring, 0);

        // Async reset while ringing
        set_now(16'h0714);
        @(negedge clk);
        set_now(16'h0715);
        @(negedge clk);
        chk("t5_ring_on", ring, 1);
        rst = 1'b1;
        #1;
        chk("t5_async_ring", ring, 0);
        chk("t5_async_alarm", alarm_w, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        set_now(16'h9999);

        // Armed 00:00, edit to 12:34 while now=00:00: no ring
        keys(0, 0, 1);
        chk("t5_armed", armed, 1);
        keys(1, 0, 0);
        incn(1);
        keys(1, 0, 0);
        incn(2);
        keys(1, 0, 0);
        incn(3);
        keys(1, 0, 0);
        incn(4);
        chk("t5_disp1234", disp_w, 16'h1234);
        chk("t5_sel3", digit_sel, 3);
        set_now(16'h0000);
        idle(3);
        chk("t5_edit_noring", ring, 0);
        chk("t5_edit_still", editing, 1);
        keys(0, 0, 1);
        chk("t5_commit_alarm", alarm_w, 16'h1234);
        chk("t5_commit_noring", ring, 0);

        // Match already high on return to IDLE via unchanged commit
        keys(1, 0, 0);
        set_now(16'h1234);
        idle(3);
        chk("t5_match_edit", ring, 0);
        keys(0, 0, 1);
        chk("t5_unch_armed", armed, 1);
        chk("t5_unch_alarm", alarm_w, 16'h1234);
        idle(3);
        chk("t5_unch_noring", ring, 0);

        // Reset mid-edit
        keys(1, 0, 0);
        incn(1);
        chk("t6_disp2234", disp_w, 16'h2234);
        rst = 1'b1;
        #1;
        chk("t6_alarm", alarm_w, 16'h0000);
        chk("t6_disp", disp_w, 16'h0000);
        chk("t6_armed", armed, 0);
        chk("t6_editing", editing, 0);
        chk("t6_sel", digit_sel, 0);
        @(negedge clk);
        rst = 1'b0;
        keys(1, 0, 0);
        chk("t6_reedit", disp_w, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
Controller that sequences alarm-time entry for the timer display and owns the committed alarm registers (HH:MM, four BCD digits). It also detects the alarm match against the running time and drives the ring output.
- Three debounced single-cycle key pulses step through digit editing with BCD wrap rules, then commit or re-arm the alarm.
- Sits between the key debouncers, the time counter and the display mux.

Parameters:
RING_SECS, 30, ring duration in sec_tick pulses before auto-silence (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
key_set  input  1  one-cycle pulse: enter edit / advance digit / silence ring
key_inc  input  1  one-cycle pulse: increment selected digit / silence ring
key_ok  input  1  one-cycle pulse: commit edit / toggle armed / silence ring
sec_tick  input  1  one-cycle pulse per second from time base
now_h1  input  4  current hour tens, BCD
now_h2  input  4  current hour ones, BCD
now_m1  input  4  current minute tens, BCD
now_m2  input  4  current minute ones, BCD
alarm_h1, alarm_h2, alarm_m1, alarm_m2  output  4 each  committed alarm digits, BCD
disp_h1, disp_h2, disp_m1, disp_m2  output  4 each  edit digits while editing, else committed digits
editing  output  1  high in any EDIT state
digit_sel  output  2  0=H1, 1=H2, 2=M1, 3=M2; 0 outside edit
blink  output  1  blank-phase for selected digit (1=show)
armed  output  1  alarm enabled
ring  output  1  alarm sounding

Behaviour:
- Reset (async, rst=1):
  - state IDLE
  - alarm digits 0 (00:00), edit digits 0
  - armed 0, ring 0, blink 1, digit_sel 0
  - ring counter 0, match_q 0
- All outputs are registered. A key pulse at edge N is reflected at the outputs after edge N.
- Key priority when pulses coincide: ok > set > inc. Only the winning key acts.
- States: IDLE, EDIT_H1, EDIT_H2, EDIT_M1, EDIT_M2, RING.
- IDLE:
  - key_set: copy the alarm digits into the edit digits, go to EDIT_H1.
  - key_ok: toggle armed.
  - key_inc: ignored.
- EDIT_x:
  - key_set: advance H1->H2->M1->M2->H1.
  - key_inc: increment the selected edit digit (wrap rules below).
  - key_ok: copy the edit digits to the alarm digits, set armed=1, go to IDLE.
  - Edit digits do not affect the alarm digits until commit.
- Increment wrap rules:
  - H1: 0..2, 2->0. When H1 becomes 2 and H2>3, H2 is forced to 0 in the same cycle.
  - H2: 0..9, 9->0. When H1==2 the range is 0..3, 3->0.
  - M1: 0..5, 5->0.
  - M2: 0..9, 9->0.
- blink:
  - Set to 1 on entering edit and on every key action in edit.
  - Toggles on each sec_tick while editing.
  - Forced to 1 outside edit.
- Match detection:
  - match = (now digits == alarm digits); match_q is match registered each cycle.
  - Trigger fires when match & ~match_q & armed & state==IDLE.
  - A match present while editing or while disarmed never triggers, including the moment the block returns to IDLE with match already high. Only a new rising edge triggers.
- RING:
  - On trigger: ring=1, counter=RING_SECS.
  - Counter decrements on each sec_tick. When the counter reaches 0: ring=0, go to IDLE.
  - Any key pulse: ring=0, go to IDLE. armed stays 1 and the key has no other effect (key_set does not enter edit, key_ok does not toggle armed).
  - A sec_tick coinciding with a key: the key wins.
- Commit with unchanged digits is legal. armed is still set to 1.
- Reset mid-edit discards the edit digits and restores the reset values. Reset mid-ring clears ring immediately (async).

Test Plan:
- Reset then key_set, key_inc x2 (H1=2), key_set, key_inc x5 (H2 wraps at 3: 0,1,2,3,0,1), key_set, key_inc x3, key_set, key_inc x7, key_ok -> alarm=21:37, armed=1, editing=0, disp=21:37.
- From alarm 19:00, key_set, key_inc x1 on H1 (1->2) -> edit H2 forced 0, disp=20:00; key_inc on M1 x6 -> M1 wraps 5->0.
- Armed alarm 07:15, drive now 07:14 then 07:15 -> ring=1 one cycle after the now change; 30 sec_ticks -> ring=0, state IDLE; holding now=07:15 -> no retrigger.
- Ringing, key_set pulse -> ring=0 next cycle, editing stays 0, armed=1; simultaneous key_ok+key_inc in IDLE -> only armed toggles.
- Edit to 12:34 without commit, now=00:00 with armed alarm 00:00 while in EDIT -> no ring; key_ok -> no ring (edge already passed); assert rst mid-edit -> all digits 0, armed=0.
